// File: rtl/udp_loopback_ctrl_if.sv
// Handshake bundle between the UDP rx/tx datapaths and the loopback sequencer.
// The slave side is the sequencer; the master side is the datapath pair (or a bench).
interface udp_loopback_ctrl_if;
   logic        rec_data_en;
   logic [31:0] rec_data;
   logic        rec_end;
   logic [15:0] rec_data_num;
   logic        read_data_req;
   logic        send_end;
   logic        send_en;
   logic [15:0] send_data_num;
   logic [31:0] send_data;

   modport master (
      output rec_data_en, rec_data, rec_end, rec_data_num, read_data_req, send_end,
      input  send_en, send_data_num, send_data
   );

   modport slave (
      input  rec_data_en, rec_data, rec_end, rec_data_num, read_data_req, send_end,
      output send_en, send_data_num, send_data
   );
endinterface

// File: rtl/udp_loopback_ctrl.sv
// Single-packet UDP echo sequencer: buffers one received payload, waits an
// inter-frame gap, then starts the transmitter and serves its word requests.
module udp_loopback_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int GAP_CYCLES = 16,
   parameter int TX_TIMEOUT = 65535
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   udp_loopback_ctrl_if.slave  lb,
   output logic                busy,
   output logic [15:0]         drop_cnt,
   output logic [15:0]         timeout_cnt
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TW    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RX, S_GAP, S_START, S_TX} state_t;

   state_t            state, state_nxt;
   logic [31:0]       mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr, rd_ptr, words, wr_cnt_nxt;
   logic              ovf;
   logic [GW-1:0]     gap_cnt;
   logic [TW-1:0]     tx_cnt;
   logic              send_en_r;
   logic [15:0]       send_num_r;
   logic [31:0]       send_data_r;

   logic              rx_phase, wr_fire, ovf_hit, pkt_ok, gap_done, tx_expire;
   logic              drop_inc, to_inc;
   logic [16:0]       need_words;

   assign lb.send_en       = send_en_r;
   assign lb.send_data_num = send_num_r;
   assign lb.send_data     = send_data_r;

   // Words written includes the one arriving alongside rec_end.
   always_comb begin
      rx_phase   = (state == S_IDLE) || (state == S_RX);
      wr_fire    = rx_phase && lb.rec_data_en && (wr_ptr != (ADDR_W+1)'(DEPTH));
      ovf_hit    = rx_phase && lb.rec_data_en && (wr_ptr == (ADDR_W+1)'(DEPTH));
      wr_cnt_nxt = wr_ptr + (ADDR_W+1)'(wr_fire);
      need_words = ({1'b0, lb.rec_data_num} + 17'd3) >> 2;
      pkt_ok     = !(ovf || ovf_hit) && (lb.rec_data_num != 16'd0) &&
                   (need_words == 17'(wr_cnt_nxt));
      gap_done   = (gap_cnt == GW'(GAP_CYCLES - 1));
      tx_expire  = (tx_cnt == TW'(TX_TIMEOUT - 1));
      drop_inc   = lb.rec_end && !(rx_phase && pkt_ok);
      to_inc     = (state == S_TX) && !lb.send_end && tx_expire;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (lb.rec_end)          state_nxt = pkt_ok ? S_GAP : S_IDLE;
            else if (lb.rec_data_en) state_nxt = S_RX;
         end
         S_RX:    if (lb.rec_end) state_nxt = pkt_ok ? S_GAP : S_IDLE;
         S_GAP:   if (gap_done) state_nxt = S_START;
         S_START: state_nxt = S_TX;
         S_TX:    if (lb.send_end || tx_expire) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Buffer has no reset; only words below the latched count are ever read.
   always_ff @(posedge sys_clk) begin
      if (wr_fire) mem[wr_ptr[ADDR_W-1:0]] <= lb.rec_data;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         words       <= '0;
         ovf         <= 1'b0;
         gap_cnt     <= '0;
         tx_cnt      <= '0;
         send_en_r   <= 1'b0;
         send_num_r  <= '0;
         send_data_r <= '0;
         busy        <= 1'b0;
         drop_cnt    <= '0;
         timeout_cnt <= '0;
      end else begin
         send_en_r <= (state == S_GAP) && gap_done;
         busy      <= !rx_phase;
         gap_cnt   <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
         tx_cnt    <= (state == S_TX)  ? tx_cnt + 1'b1  : '0;

         if (state_nxt == S_IDLE) begin
            wr_ptr <= '0;
            ovf    <= 1'b0;
         end else if (rx_phase) begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (ovf_hit) ovf    <= 1'b1;
         end

         if (rx_phase && lb.rec_end && pkt_ok) begin
            send_num_r <= lb.rec_data_num;
            words      <= wr_cnt_nxt;
         end

         if (drop_inc && drop_cnt != 16'hFFFF)  drop_cnt    <= drop_cnt + 1'b1;
         if (to_inc && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 1'b1;

         // Requests past the payload return zero padding without moving rd_ptr.
         if (state == S_START) begin
            rd_ptr <= '0;
         end else if (state == S_TX && lb.read_data_req) begin
            if (rd_ptr < words) begin
               send_data_r <= mem[rd_ptr[ADDR_W-1:0]];
               rd_ptr      <= rd_ptr + 1'b1;
            end else begin
               send_data_r <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_udp_loopback_ctrl.sv
// Randomized bench for udp_loopback_ctrl against a packet-level echo model.
module tb_udp_loopback_ctrl;
   localparam int G     = 16;
   localparam int TO    = 100;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        busy;
   logic [15:0] drop_cnt, timeout_cnt;

   udp_loopback_ctrl_if lb();

   udp_loopback_ctrl #(.ADDR_W(AW), .GAP_CYCLES(G), .TX_TIMEOUT(TO)) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .lb          (lb),
      .busy        (busy),
      .drop_cnt    (drop_cnt),
      .timeout_cnt (timeout_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int          checks = 0, errors = 0;
   int          drop_exp = 0, to_exp = 0, cyc = 0;
   logic [31:0] words_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic feed(input int nw, input int num, input bit gaps);
      logic [31:0] w;
      words_q.delete();
      for (int i = 0; i < nw; i++) begin
         w = $urandom;
         words_q.push_back(w);
         lb.rec_data_en = 1'b1;
         lb.rec_data    = w;
         if (i == nw - 1) begin
            lb.rec_end      = 1'b1;
            lb.rec_data_num = 16'(num);
         end
         step();
         lb.rec_data_en = 1'b0;
         lb.rec_end     = 1'b0;
         if (gaps && i < nw - 1) repeat ($urandom_range(0, 2)) step();
      end
   endtask

   task automatic run_pkt(input int nw, input int num, input int nreads,
                          input bit intrude, input bit tmo, input bit gaps);
      logic [31:0] exp_q[$];
      logic [31:0] e;
      int          n, t_en;
      bit          found, seen;
      feed(nw, num, gaps);
      exp_q = words_q;
      if (!(nw <= DEPTH && num != 0 && (num + 3) / 4 == nw)) begin
         drop_exp++;
         seen = 1'b0;
         repeat (G + 4) begin
            step();
            seen |= lb.send_en;
         end
         chk("no_send_en", 32'(seen), 32'd0);
         chk("drop", 32'(drop_cnt), 32'(drop_exp));
         chk("busy_drop", 32'(busy), 32'd0);
         return;
      end
      chk("busy_rx", 32'(busy), 32'd0);
      n = 0;
      found = 1'b0;
      while (n < G + 4 && !found) begin
         step();
         n++;
         if (n == 1) chk("busy_gap", 32'(busy), 32'd1);
         found = lb.send_en;
      end
      t_en = cyc;
      chk("start_dly", n, G);
      chk("num", 32'(lb.send_data_num), 32'(num));
      step();
      chk("en_pulse", 32'(lb.send_en), 32'd0);
      for (int r = 0; r < nreads; r++) begin
         if (intrude && r == 1) begin
            feed(2, 8, 1'b0);
            drop_exp++;
            chk("drop_tx", 32'(drop_cnt), 32'(drop_exp));
         end
         lb.read_data_req = 1'b1;
         lb.send_end      = !tmo && (r == nreads - 1);
         step();
         lb.read_data_req = 1'b0;
         lb.send_end      = 1'b0;
         e = (r < nw) ? exp_q[r] : 32'd0;
         chk("rd", lb.send_data, e);
         if (r < nreads - 1) begin
            repeat ($urandom_range(0, 2)) step();
            chk("rd_hold", lb.send_data, e);
         end
      end
      if (!tmo) begin
         step();
         chk("busy_end", 32'(busy), 32'd0);
      end else begin
         while (cyc - t_en < TO) step();
         chk("to_pre", 32'(timeout_cnt), 32'(to_exp));
         step();
         to_exp++;
         chk("to_cnt", 32'(timeout_cnt), 32'(to_exp));
         step();
         chk("busy_to", 32'(busy), 32'd0);
      end
      chk("drop", 32'(drop_cnt), 32'(drop_exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nw, num, nr;
      bit seen;
      lb.rec_data_en   = 1'b0;
      lb.rec_data      = '0;
      lb.rec_end       = 1'b0;
      lb.rec_data_num  = '0;
      lb.read_data_req = 1'b0;
      lb.send_end      = 1'b0;
      #1;
      chk("rst_en",   32'(lb.send_en), 32'd0);
      chk("rst_num",  32'(lb.send_data_num), 32'd0);
      chk("rst_data", lb.send_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_to",   32'(timeout_cnt), 32'd0);
      repeat (2) step();
      sys_rst_n = 1'b1;
      step();

      run_pkt(2, 8, 3, 1'b0, 1'b0, 1'b0);
      run_pkt(2, 5, 2, 1'b0, 1'b0, 1'b1);
      run_pkt(3, 12, 4, 1'b1, 1'b0, 1'b0);
      run_pkt(257, 1028, 0, 1'b0, 1'b0, 1'b0);
      run_pkt(1, 4, 2, 1'b0, 1'b0, 1'b0);
      run_pkt(1, 0, 0, 1'b0, 1'b0, 1'b0);
      run_pkt(3, 4, 0, 1'b0, 1'b0, 1'b0);

      for (int it = 0; it < 10; it++) begin
         nw  = $urandom_range(1, 6);
         num = 4 * nw - $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) num += 4;
         nr  = $urandom_range(1, nw + 2);
         run_pkt(nw, num, nr, (nr >= 2) && ($urandom_range(0, 1) == 1), 1'b0, 1'b1);
         repeat ($urandom_range(0, 3)) step();
      end

      run_pkt(2, 8, 1, 1'b0, 1'b1, 1'b0);

      feed(2, 8, 1'b0);
      repeat (5) step();
      #2 sys_rst_n = 1'b0;
      #1;
      drop_exp = 0;
      to_exp   = 0;
      chk("grst_en",   32'(lb.send_en), 32'd0);
      chk("grst_num",  32'(lb.send_data_num), 32'd0);
      chk("grst_data", lb.send_data, 32'd0);
      chk("grst_busy", 32'(busy), 32'd0);
      chk("grst_drop", 32'(drop_cnt), 32'd0);
      chk("grst_to",   32'(timeout_cnt), 32'd0);
      repeat (2) step();
      sys_rst_n = 1'b1;
      seen = 1'b0;
      repeat (G + 10) begin
         step();
         seen |= lb.send_en;
      end
      chk("grst_no_en", 32'(seen), 32'd0);
      chk("grst_idle", 32'(busy), 32'd0);

      run_pkt(2, 7, 2, 1'b0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
